// File: rtl/hyper_mvblck_lsab2dram_pkg.sv
// Shared types and widths for the LSAB-to-DRAM block mover.
package hyper_mvblck_pkg;

    localparam int SECT_W = 2;
    localparam int CNT_W  = 6;
    localparam int COL_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef logic [(1 << SECT_W)-1:0] sect_onehot_t;

    function automatic sect_onehot_t sect_decode(input logic [SECT_W-1:0] sec);
        sect_onehot_t hot;
        hot      = '0;
        hot[sec] = 1'b1;
        return hot;
    endfunction

endpackage

// File: rtl/hyper_mvblck_lsab2dram_if.sv
// Command, LSAB read and DRAM column write signals of the block mover.
interface hyper_mvblck_lsab2dram_if
    import hyper_mvblck_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_SECT = 4
);

    logic [COL_W-1:0]  BLCK_START;
    logic [CNT_W-1:0]  BLCK_COUNT_REQ;
    logic              BLCK_ISSUE;
    logic [SECT_W-1:0] BLCK_SECTION;
    logic [CNT_W-1:0]  BLCK_COUNT_SENT;
    logic              BLCK_WORKING;
    logic [N_SECT-1:0] LSAB_EMPTY;
    logic [N_SECT-1:0] LSAB_READ;
    logic [DATA_W-1:0] LSAB_DATA;
    logic [COL_W-1:0]  MCU_COL_ADDR;
    logic              MCU_WE;
    logic [DATA_W-1:0] MCU_DATA;

    // The mover is the responder, so its view is the slave modport.
    modport slave (
        input  BLCK_START, BLCK_COUNT_REQ, BLCK_ISSUE, BLCK_SECTION,
        input  LSAB_EMPTY, LSAB_DATA,
        output BLCK_COUNT_SENT, BLCK_WORKING, LSAB_READ,
        output MCU_COL_ADDR, MCU_WE, MCU_DATA
    );

    modport master (
        output BLCK_START, BLCK_COUNT_REQ, BLCK_ISSUE, BLCK_SECTION,
        output LSAB_EMPTY, LSAB_DATA,
        input  BLCK_COUNT_SENT, BLCK_WORKING, LSAB_READ,
        input  MCU_COL_ADDR, MCU_WE, MCU_DATA
    );

endinterface

// File: rtl/hyper_mvblck_lsab2dram_wpipe.sv
// Two-stage pipe: read strobe -> LSAB data capture -> DRAM column write.
module hyper_mvblck_wpipe
    import hyper_mvblck_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_stb,
    input  logic [COL_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              we,
    output logic [COL_W-1:0]  col_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        occupancy
);

    logic             vld1;
    logic [COL_W-1:0] addr1;

    // Stage 1 tracks the strobe; LSAB data only arrives one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1     <= 1'b0;
            addr1    <= '0;
            we       <= 1'b0;
            col_addr <= '0;
            wr_data  <= '0;
        end else begin
            vld1 <= rd_stb;
            if (rd_stb) begin
                addr1 <= rd_addr;
            end
            we <= vld1;
            if (vld1) begin
                col_addr <= addr1;
                wr_data  <= rd_data;
            end else begin
                wr_data  <= '0;
            end
        end
    end

    assign occupancy = {we, vld1};

endmodule

// File: rtl/hyper_mvblck_lsab2dram.sv
// Block mover: drains one LSAB section into consecutive DRAM columns on BLCK_ISSUE.
module hyper_mvblck_lsab2dram
    import hyper_mvblck_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_SECT = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    hyper_mvblck_lsab2dram_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  count_sent;
    logic [COL_W-1:0]  start_col;
    logic [SECT_W-1:0] sec_q;
    logic              working;
    logic              rd_ok;
    logic              sec_empty;
    logic              pipe_busy;
    logic [1:0]        occupancy;
    logic [N_SECT-1:0] sec_hot;

    assign sec_hot   = N_SECT'(sect_decode(sec_q));
    assign sec_empty = |(bus.LSAB_EMPTY & sec_hot);
    assign pipe_busy = |occupancy;

    // An empty section ends the transfer at once; the mover never waits for refill.
    always_comb begin
        state_nxt = state;
        rd_ok     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.BLCK_ISSUE) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if ((rem != '0) && !sec_empty) begin
                    rd_ok = 1'b1;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            rem        <= '0;
            rd_cnt     <= '0;
            count_sent <= '0;
            start_col  <= '0;
            sec_q      <= '0;
            working    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && bus.BLCK_ISSUE) begin
                start_col <= bus.BLCK_START;
                rem       <= bus.BLCK_COUNT_REQ;
                sec_q     <= bus.BLCK_SECTION;
                rd_cnt    <= '0;
                working   <= 1'b1;
            end
            if (rd_ok) begin
                rem    <= rem - CNT_W'(1);
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            // COUNT_SENT only moves when a transfer finishes, never at issue.
            if ((state == DRAIN) && !pipe_busy) begin
                working    <= 1'b0;
                count_sent <= rd_cnt;
            end
        end
    end

    assign bus.LSAB_READ       = rd_ok ? sec_hot : '0;
    assign bus.BLCK_WORKING    = working;
    assign bus.BLCK_COUNT_SENT = count_sent;

    hyper_mvblck_wpipe #(
        .DATA_W (DATA_W)
    ) u_wpipe (
        .clk       (CLK),
        .rst_n     (RST),
        .rd_stb    (rd_ok),
        .rd_addr   (start_col + COL_W'(rd_cnt)),
        .rd_data   (bus.LSAB_DATA),
        .we        (bus.MCU_WE),
        .col_addr  (bus.MCU_COL_ADDR),
        .wr_data   (bus.MCU_DATA),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_hyper_mvblck_lsab2dram.sv
// Directed bench for the LSAB-to-DRAM block mover with a small LSAB model.
module tb_hyper_mvblck_lsab2dram;

    logic CLK;
    logic RST;

    hyper_mvblck_lsab2dram_if #(.DATA_W(32), .N_SECT(4)) bus ();

    hyper_mvblck_lsab2dram #(.DATA_W(32), .N_SECT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] start;
        logic [5:0]  req;
        logic [1:0]  sect;
        int          fillAdd;
        int          expSent;
        int          expWork;
    } vec_t;

    int checks;
    int failures;
    int fill [4];
    int pops [4];
    int wrTotal, rdTotal, workTotal;
    int wrBase, rdBase, workBase;
    logic [11:0] expStart;
    logic [1:0]  expSect;
    int          expBase;

    function automatic logic [31:0] lsabWord(input int s, input int k);
        return 32'hD000_0000 + (32'(s) << 20) + 32'(k);
    endfunction

    // LSAB model: words pop on the strobe edge and show up on LSAB_DATA the next cycle.
    always @(posedge CLK) begin
        for (int s = 0; s < 4; s++) begin
            if (bus.LSAB_READ[s]) begin
                pops[s]       <= pops[s] + 1;
                bus.LSAB_DATA <= lsabWord(s, pops[s]);
            end
        end
    end

    always_comb begin
        bus.LSAB_EMPTY = '1;
        for (int s = 0; s < 4; s++) begin
            bus.LSAB_EMPTY[s] = (pops[s] >= fill[s]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; sample on the falling edge and score reads and writes.
    task automatic tick();
        int idx;
        @(negedge CLK);
        if (bus.BLCK_WORKING === 1'b1) workTotal++;
        if (bus.LSAB_READ !== 4'b0000) begin
            rdTotal++;
            checkOutput("read_onehot", 32'(bus.LSAB_READ), 32'(1) << expSect);
            checkOutput("read_not_empty", 32'(bus.LSAB_READ & bus.LSAB_EMPTY), 32'd0);
            checkOutput("read_while_busy", 32'(bus.BLCK_WORKING), 32'd1);
        end
        if (bus.MCU_WE === 1'b1) begin
            idx = wrTotal - wrBase;
            checkOutput("wr_col", 32'(bus.MCU_COL_ADDR), 32'(12'(32'(expStart) + idx)));
            checkOutput("wr_data", bus.MCU_DATA, lsabWord(32'(expSect), expBase + idx));
            wrTotal++;
        end
    endtask

    task automatic applyStimulus(input logic [11:0] start, input logic [5:0] req, input logic [1:0] sect);
        expStart = start;
        expSect  = sect;
        expBase  = pops[sect];
        wrBase   = wrTotal;
        rdBase   = rdTotal;
        workBase = workTotal;
        bus.BLCK_START     = start;
        bus.BLCK_COUNT_REQ = req;
        bus.BLCK_SECTION   = sect;
        bus.BLCK_ISSUE     = 1'b1;
        tick();
        bus.BLCK_ISSUE     = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (bus.BLCK_WORKING === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("done_in_time", 32'(bus.BLCK_WORKING), 32'd0);
    endtask

    task automatic checkTransfer(input int expSent, input int expWork);
        checkOutput("count_sent", 32'(bus.BLCK_COUNT_SENT), 32'(expSent));
        checkOutput("write_count", 32'(wrTotal - wrBase), 32'(expSent));
        checkOutput("read_count", 32'(rdTotal - rdBase), 32'(expSent));
        checkOutput("working_cycles", 32'(workTotal - workBase), 32'(expWork));
        checkOutput("idle_we", 32'(bus.MCU_WE), 32'd0);
        checkOutput("idle_data", bus.MCU_DATA, 32'd0);
        checkOutput("idle_read", 32'(bus.LSAB_READ), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_working"}, 32'(bus.BLCK_WORKING), 32'd0);
        checkOutput({tag, "_count_sent"}, 32'(bus.BLCK_COUNT_SENT), 32'd0);
        checkOutput({tag, "_read"}, 32'(bus.LSAB_READ), 32'd0);
        checkOutput({tag, "_we"}, 32'(bus.MCU_WE), 32'd0);
        checkOutput({tag, "_data"}, bus.MCU_DATA, 32'd0);
        checkOutput({tag, "_col"}, 32'(bus.MCU_COL_ADDR), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        int   n;
        int   wrMark;

        vecs[0] = '{start: 12'h010, req: 6'd16, sect: 2'd2, fillAdd: 40, expSent: 16, expWork: 19};
        vecs[1] = '{start: 12'h100, req: 6'd20, sect: 2'd1, fillAdd: 5,  expSent: 5,  expWork: 8};
        vecs[2] = '{start: 12'hFFE, req: 6'd4,  sect: 2'd3, fillAdd: 8,  expSent: 4,  expWork: 7};
        vecs[3] = '{start: 12'h123, req: 6'd0,  sect: 2'd0, fillAdd: 8,  expSent: 0,  expWork: 2};
        vecs[4] = '{start: 12'h200, req: 6'd7,  sect: 2'd1, fillAdd: 0,  expSent: 0,  expWork: 2};
        vecs[5] = '{start: 12'h3F0, req: 6'd63, sect: 2'd0, fillAdd: 70, expSent: 63, expWork: 66};

        checks    = 0;
        failures  = 0;
        wrTotal   = 0;
        rdTotal   = 0;
        workTotal = 0;
        wrBase    = 0;
        rdBase    = 0;
        workBase  = 0;
        expStart  = '0;
        expSect   = '0;
        expBase   = 0;
        RST                = 1'b0;
        bus.BLCK_START     = '0;
        bus.BLCK_COUNT_REQ = '0;
        bus.BLCK_SECTION   = '0;
        bus.BLCK_ISSUE     = 1'b0;

        repeat (3) tick();
        checkAllZero("reset");
        RST = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            fill[vecs[v].sect] += vecs[v].fillAdd;
            applyStimulus(vecs[v].start, vecs[v].req, vecs[v].sect);
            waitDone();
            checkTransfer(vecs[v].expSent, vecs[v].expWork);
            tick();
        end

        // A second ISSUE mid-transfer must not disturb the latched command.
        applyStimulus(12'h050, 6'd10, 2'd2);
        tick();
        tick();
        bus.BLCK_START     = 12'h777;
        bus.BLCK_COUNT_REQ = 6'd5;
        bus.BLCK_SECTION   = 2'd0;
        bus.BLCK_ISSUE     = 1'b1;
        tick();
        bus.BLCK_ISSUE     = 1'b0;
        checkOutput("stale_sent_held", 32'(bus.BLCK_COUNT_SENT), 32'd63);
        waitDone();
        checkTransfer(10, 13);
        tick();

        // Reset lands after six words of a thirty-word transfer.
        fill[3] += 40;
        applyStimulus(12'h400, 6'd30, 2'd3);
        n = 0;
        while ((wrTotal - wrBase) < 6 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("six_writes_seen", 32'(wrTotal - wrBase), 32'd6);
        #2;
        RST = 1'b0;
        #1;
        checkAllZero("async_reset");
        tick();
        tick();
        RST = 1'b1;
        wrMark = wrTotal;
        repeat (8) tick();
        checkOutput("no_we_after_reset", 32'(wrTotal - wrMark), 32'd0);
        checkOutput("idle_after_reset", 32'(bus.BLCK_WORKING), 32'd0);

        applyStimulus(12'h010, 6'd3, 2'd3);
        waitDone();
        checkTransfer(3, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
